picmicro_pc_stack_unit: RTL

- Program-counter and hardware return-stack stage of the midrange core.
- Feeds the program-memory fetch address, and consumes the control unit's jump, push and pop strobes.
- Updates once per instruction cycle, on the Q4 step strobe.
- Forms goto/call targets with PCLATH, computed jumps on PCL writes, and returns through an 8-level circular stack.

---
 rtl/picmicro_pkg.sv | 20 ++
 rtl/picmicro_hw_stack.sv | 59 +++++
 rtl/picmicro_pc_stack_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/picmicro_pkg.sv
// Shared constants, address type and PC-source decode for the PC/stack stage.
// Imported by picmicro_hw_stack and picmicro_pc_stack_unit.
package picmicro_pkg;

    localparam int              PC_WIDTH     = 13;
    localparam int              STACK_DEPTH  = 8;
    localparam logic [12:0]     RESET_VECTOR = 13'h0000;

    typedef logic [12:0] pc_addr_t;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_GOTO,
        PC_PCL,
        PC_CALL,
        PC_RET
    } pc_src_e;

endpackage

// File: rtl/picmicro_hw_stack.sv
// Circular return stack with pointer, depth count and ovf/unf events.
// Ports: push/pop strobes, din (pushed pc), dout (top), depth, ovf_evt, unf_evt.
module picmicro_hw_stack
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf_evt,
    output logic                       unf_evt
);
    import picmicro_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic             full;
    logic             empty;

    assign top_idx = ptr - 1'b1;
    assign full    = (depth == (PW+1)'(DEPTH));
    assign empty   = (depth == '0);
    assign dout    = empty ? '0 : mem[top_idx];
    assign ovf_evt = push & full;
    assign unf_evt = pop & empty;

    // When full, ptr already points at the oldest entry, so a push
    // overwrites it and the ring keeps the newest DEPTH addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            depth <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop) begin
            if (!empty) begin
                ptr   <= top_idx;
                depth <= depth - 1'b1;
            end
        end else if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + 1'b1;
            if (!full) begin
                depth <= depth + 1'b1;
            end
        end
    end

endmodule

// File: rtl/picmicro_pc_stack_unit.sv
// Program counter and return-stack stage; updates on the Q4 step strobe.
// Ports: step_en, jump/push/pop/pcl/inc strobes, jaddr, pcl_data, pclath in;
// pc_out, stack_out, stack_depth, stack_ovf, stack_unf, stack_err_rst out.
// Option: define PICMICRO_STACK_ERR_RESET_EN for sticky flags and err reset.
module picmicro_pc_stack_unit
#(
    parameter int                    PC_WIDTH     = picmicro_pkg::PC_WIDTH,
    parameter int                    STACK_DEPTH  = picmicro_pkg::STACK_DEPTH,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = picmicro_pkg::RESET_VECTOR
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_en,
    input  logic                 pc_inc_en,
    input  logic                 pc_j_en,
    input  logic                 pc_j_and_push_en,
    input  logic                 pc_j_by_pop_en,
    input  logic                 pcl_write_en,
    input  logic [10:0]          jaddr,
    input  logic [7:0]           pcl_data,
    input  logic [4:0]           pclath,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [PC_WIDTH-1:0]  stack_out,
    output logic [3:0]           stack_depth,
    output logic                 stack_ovf,
    output logic                 stack_unf,
    output logic                 stack_err_rst
);
    import picmicro_pkg::*;

    localparam int DW = $clog2(STACK_DEPTH) + 1;

    pc_src_e            src;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [PC_WIDTH-1:0] jtarget;
    logic [DW-1:0]       depth;
    logic                push;
    logic                pop;
    logic                ovf_evt;
    logic                unf_evt;

    always_comb begin
        src = PC_HOLD;
        priority case (1'b1)
            pc_j_by_pop_en:   src = PC_RET;
            pc_j_and_push_en: src = PC_CALL;
            pc_j_en:          src = PC_GOTO;
            pcl_write_en:     src = PC_PCL;
            pc_inc_en:        src = PC_INC;
            default:          src = PC_HOLD;
        endcase
    end

    assign push    = step_en & (src == PC_CALL);
    assign pop     = step_en & (src == PC_RET);
    assign jtarget = PC_WIDTH'({pclath[4:3], jaddr});

    always_comb begin
        pc_nxt = pc;
        unique case (src)
            PC_RET:  pc_nxt = unf_evt ? '0 : stack_out;
            PC_CALL: pc_nxt = jtarget;
            PC_GOTO: pc_nxt = jtarget;
            PC_PCL:  pc_nxt = PC_WIDTH'({pclath, pcl_data});
            PC_INC:  pc_nxt = pc + 1'b1;
            default: pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else if (step_en) begin
            pc <= pc_nxt;
        end
    end

    picmicro_hw_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .din     (pc),
        .dout    (stack_out),
        .depth   (depth),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    assign pc_out      = pc;
    assign stack_depth = 4'(depth);

`ifdef PICMICRO_STACK_ERR_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_ovf     <= 1'b0;
            stack_unf     <= 1'b0;
            stack_err_rst <= 1'b0;
        end else begin
            if (ovf_evt) begin
                stack_ovf <= 1'b1;
            end
            if (unf_evt) begin
                stack_unf <= 1'b1;
            end
            stack_err_rst <= ovf_evt | unf_evt;
        end
    end
`else
    logic unused_evt;
    assign unused_evt    = ovf_evt;
    assign stack_ovf     = 1'b0;
    assign stack_unf     = 1'b0;
    assign stack_err_rst = 1'b0;
`endif

endmodule
